// File: rtl/pwm_deadtime_gen.sv
// Complementary half-bridge gate driver with programmable dead time on every PWM edge.
// Optional abort counter output enabled by defining DEADTIME_ABORT_CNT_EN.
module pwm_deadtime_gen #(
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_cycles,
  output logic            gate_hi,
  output logic            gate_lo,
  output logic            dt_active
`ifdef DEADTIME_ABORT_CNT_EN
  ,
  output logic [7:0]      abort_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DT_RISE = 3'd1,
    HIGH    = 3'd2,
    DT_FALL = 3'd3,
    LOW     = 3'd4
  } state_t;

  localparam logic [DT_W-1:0] CNT_ONE  = DT_W'(1);
  localparam logic [DT_W-1:0] CNT_ZERO = DT_W'(0);

  state_t          state_q, state_d;
  logic            pwm_q, pwm_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            gate_hi_q, gate_hi_d;
  logic            gate_lo_q, gate_lo_d;
  logic            dt_active_q, dt_active_d;
  logic [DT_W-1:0] cnt_load_s;
  logic            abort_s;

  // Zero dead time is promoted to one cycle; the counter holds remaining cycles minus one.
  always_comb begin
    if (dead_cycles == CNT_ZERO) begin
      cnt_load_s = CNT_ZERO;
    end else begin
      cnt_load_s = dead_cycles - CNT_ONE;
    end
  end

  // Next-state and next-output logic; an abort beats counter expiry on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_s = 1'b0;
    pwm_d   = pwm_in;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = pwm_q ? DT_RISE : DT_FALL;
          cnt_d   = cnt_load_s;
        end
        LOW: begin
          if (pwm_q) begin
            state_d = DT_RISE;
            cnt_d   = cnt_load_s;
          end else begin
            state_d = LOW;
          end
        end
        HIGH: begin
          if (!pwm_q) begin
            state_d = DT_FALL;
            cnt_d   = cnt_load_s;
          end else begin
            state_d = HIGH;
          end
        end
        DT_RISE: begin
          if (!pwm_q) begin
            state_d = LOW;
            cnt_d   = CNT_ZERO;
            abort_s = 1'b1;
          end else if (cnt_q == CNT_ZERO) begin
            state_d = HIGH;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        DT_FALL: begin
          if (pwm_q) begin
            state_d = HIGH;
            cnt_d   = CNT_ZERO;
            abort_s = 1'b1;
          end else if (cnt_q == CNT_ZERO) begin
            state_d = LOW;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
    gate_hi_d   = (state_d == HIGH);
    gate_lo_d   = (state_d == LOW);
    dt_active_d = (state_d == DT_RISE) || (state_d == DT_FALL);
  end

  // State, input sample and registered gate outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pwm_q       <= 1'b0;
      cnt_q       <= CNT_ZERO;
      gate_hi_q   <= 1'b0;
      gate_lo_q   <= 1'b0;
      dt_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_q       <= pwm_d;
      cnt_q       <= cnt_d;
      gate_hi_q   <= gate_hi_d;
      gate_lo_q   <= gate_lo_d;
      dt_active_q <= dt_active_d;
    end
  end

  assign gate_hi   = gate_hi_q;
  assign gate_lo   = gate_lo_q;
  assign dt_active = dt_active_q;

`ifdef DEADTIME_ABORT_CNT_EN
  logic [7:0] abort_cnt_q, abort_cnt_d;

  // Saturating abort count, held clear while disabled.
  always_comb begin
    if (!ena) begin
      abort_cnt_d = 8'd0;
    end else if (abort_s && (abort_cnt_q != 8'd255)) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end else begin
      abort_cnt_d = abort_cnt_q;
    end
  end

  // Abort counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_cnt_q <= 8'd0;
    end else begin
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_cnt = abort_cnt_q;
`else
  logic unused_abort_s;
  assign unused_abort_s = abort_s;
`endif

endmodule
